// File: rtl/mux_output_driver_if.sv
// Host-side bus of mux_output_driver: word write strobe plus the addressable-latch drive lines.
interface mux_output_driver_if #(
  parameter int MUX_ADDR_BITS = 4
);
  localparam int N = 1 << MUX_ADDR_BITS;

  logic                     ENABLE;
  logic [N-1:0]             DATA_IN;
  logic                     WR;
  logic                     PENDING;
  logic [MUX_ADDR_BITS-1:0] MUX_ADDR;
  logic                     DATA_OUT;
  logic                     LE_N;
  logic                     FRAME_DONE;
  logic                     BUSY;

  modport master (
    output ENABLE, DATA_IN, WR,
    input  PENDING, MUX_ADDR, DATA_OUT, LE_N, FRAME_DONE, BUSY
  );

  modport slave (
    input  ENABLE, DATA_IN, WR,
    output PENDING, MUX_ADDR, DATA_OUT, LE_N, FRAME_DONE, BUSY
  );
endinterface

// File: rtl/mux_output_driver.sv
// Scans a parallel word out through a 74HC259-style addressable latch, one slot per bit,
// re-sending the whole word every frame; host writes take effect only at a frame start.
module mux_output_driver #(
  parameter int CLK_DIV_BITS  = 5,
  parameter int MUX_ADDR_BITS = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mux_output_driver_if.slave   bus_io
);
  localparam int N = 1 << MUX_ADDR_BITS;
  localparam int Q = 1 << (CLK_DIV_BITS - 2);

  localparam logic [CLK_DIV_BITS-1:0]  DIV_MAX  = '1;
  localparam logic [MUX_ADDR_BITS-1:0] ADDR_MAX = '1;
  // Strobe window [Q, 3Q) leaves Q cycles of setup and hold around LE_N low.
  localparam logic [CLK_DIV_BITS-1:0]  LE_LO    = CLK_DIV_BITS'(Q);
  localparam logic [CLK_DIV_BITS-1:0]  LE_HI    = CLK_DIV_BITS'(3 * Q);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [CLK_DIV_BITS-1:0]  div_q, div_d;
  logic [MUX_ADDR_BITS-1:0] addr_q, addr_d;
  logic [N-1:0]             pend_q, pend_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [N-1:0]             active_q, active_d;
  logic                     data_out_q, data_out_d;
  logic                     le_n_q, le_n_d;
  logic                     frame_done_q, frame_done_d;
  logic                     busy_q, busy_d;
  logic                     frame_start;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    active_d     = active_q;
    frame_done_d = 1'b0;
    frame_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        addr_d = '0;
        if (bus_io.ENABLE) begin
          frame_start = 1'b1;
        end
      end
      ST_SCAN: begin
        if (div_q == DIV_MAX) begin
          if (addr_q == ADDR_MAX) begin
            frame_done_d = 1'b1;
            if (bus_io.ENABLE) begin
              frame_start = 1'b1;
            end else begin
              state_d = ST_IDLE;
              div_d   = '0;
              addr_d  = '0;
            end
          end else begin
            addr_d = addr_q + 1'b1;
            div_d  = '0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        addr_d  = '0;
      end
    endcase

    // The active word only ever changes here, so a frame is never emitted half-updated.
    if (frame_start) begin
      state_d = ST_SCAN;
      div_d   = '0;
      addr_d  = '0;
      if (pend_vld_q) begin
        active_d   = pend_q;
        pend_vld_d = 1'b0;
      end
    end

    // A write coinciding with a frame start is kept for the following frame.
    if (bus_io.WR) begin
      pend_d     = bus_io.DATA_IN;
      pend_vld_d = 1'b1;
    end

    busy_d     = (state_d == ST_SCAN);
    le_n_d     = !(busy_d && (div_d >= LE_LO) && (div_d < LE_HI));
    data_out_d = busy_d ? active_d[addr_d] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      addr_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      active_q     <= '0;
      data_out_q   <= 1'b0;
      le_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      active_q     <= active_d;
      data_out_q   <= data_out_d;
      le_n_q       <= le_n_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus_io.PENDING    = pend_vld_q;
  assign bus_io.MUX_ADDR   = addr_q;
  assign bus_io.DATA_OUT   = data_out_q;
  assign bus_io.LE_N       = le_n_q;
  assign bus_io.FRAME_DONE = frame_done_q;
  assign bus_io.BUSY       = busy_q;
endmodule
